// File: rtl/drawframe_cfg_pkg.sv
// Shared types and constants for the DrawFrame register-bank configuration sequencer.
package drawframe_cfg_pkg;

  // Data word width of the DrawFrame register bank.
  localparam int DATA_W = 32;

  // Byte distance between consecutive DrawFrame registers.
  localparam int REG_STRIDE = 4;

  // AXI response code for a successful transfer.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Completion codes reported on err_code together with done.
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_RESP     = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  // True when an AXI BRESP/RRESP reports success.
  function automatic logic resp_ok(input logic [1:0] resp);
    return resp == AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/drawframe_cfg_sequencer.sv
// AXI4-Lite master that writes a block of DrawFrame registers from one request,
// optionally reads them back to verify, and reports completion with an error code.
module drawframe_cfg_sequencer
  import drawframe_cfg_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            NUM_REGS           = 4,
  parameter int                            VERIFY             = 1,
  parameter int                            TIMEOUT_CYCLES     = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [DATA_W*NUM_REGS-1:0]      cfg_data,
  output logic                            done,
  output logic [1:0]                      err_code,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [DATA_W-1:0]               M_AXI_WDATA,
  output logic [3:0]                      M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [DATA_W-1:0]               M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               aw_done, aw_done_n;
  logic               w_done, w_done_n;
  logic               cfg_rdy, cfg_rdy_n;
  logic               done_q, done_n;
  logic [1:0]         err_q, err_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               load;
  logic               tmo;
  logic               tmr_clr;

  logic [DATA_W-1:0]  words [NUM_REGS];
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any;

  // Channel VALID/READY decode straight from the registered state, so they
  // fall to zero the cycle after reset or after leaving a wait state.
  assign M_AXI_AWVALID = (state == ST_WR_REQ) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR_REQ) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WR_RESP);
  assign M_AXI_ARVALID = (state == ST_RD_REQ);
  assign M_AXI_RREADY  = (state == ST_RD_DATA);

  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs   = M_AXI_BREADY  && M_AXI_BVALID;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs   = M_AXI_RREADY  && M_AXI_RVALID;
  assign hs_any = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  // Register i lives at BASE_ADDR + REG_STRIDE*i for both write and read-back.
  assign addr = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx) * C_M_AXI_ADDR_WIDTH'(REG_STRIDE));

  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA  = words[idx];
  assign M_AXI_WSTRB  = 4'hF;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign cfg_ready = cfg_rdy;
  assign done      = done_q;
  assign err_code  = err_q;

  assign tmo = (timer == TMR_LIMIT);

  // Control state register; every control flop returns to idle values on reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      idx     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cfg_rdy <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      timer   <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      cfg_rdy <= cfg_rdy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      timer   <= timer_n;
    end
  end

  // Request payload capture; data only, no reset needed.
  always_ff @(posedge ACLK) begin
    if (load) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        words[i] <= cfg_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, transaction sequencing, error capture and wait timer.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    done_n    = 1'b0;
    err_n     = err_q;
    load      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cfg_valid && cfg_rdy) begin
          state_n   = ST_WR_REQ;
          idx_n     = '0;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          err_n     = ERR_OK;
          load      = 1'b1;
        end
      end

      ST_WR_REQ: begin
        // Address and data channels complete independently, in either order.
        aw_done_n = aw_done || aw_hs;
        w_done_n  = w_done  || w_hs;
        if (aw_done_n && w_done_n) begin
          state_n = ST_WR_RESP;
        end else if (!hs_any && tmo) begin
          // A timeout takes the place of the DONE cycle so done lands
          // exactly TIMEOUT_CYCLES after the wait began.
          state_n = ST_IDLE;
          done_n  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          if (!resp_ok(M_AXI_BRESP)) begin
            state_n = ST_DONE;
            err_n   = ERR_RESP;
          end else if (idx == LAST_IDX) begin
            idx_n = '0;
            if (VERIFY != 0) begin
              state_n = ST_RD_REQ;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
            idx_n     = idx + IDX_W'(1);
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = ST_WR_REQ;
          end
        end else if (tmo) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end

      ST_RD_REQ: begin
        if (ar_hs) begin
          state_n = ST_RD_DATA;
        end else if (tmo) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          if (!resp_ok(M_AXI_RRESP)) begin
            state_n = ST_DONE;
            err_n   = ERR_RESP;
          end else if (M_AXI_RDATA != words[idx]) begin
            state_n = ST_DONE;
            err_n   = ERR_MISMATCH;
          end else if (idx == LAST_IDX) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = ST_RD_REQ;
          end
        end else if (tmo) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    cfg_rdy_n = (state_n == ST_IDLE);

    // The timer measures one wait at a time: any state change or handshake restarts it.
    tmr_clr = (state_n != state) || hs_any || (state == ST_IDLE) || (state == ST_DONE);
    timer_n = tmr_clr ? '0 : timer + TMR_W'(1);
  end

endmodule
